// File: rtl/sample_rr_sched_if.sv
// Handshake bundle for sample_rr_sched: N sampled inputs, one tagged output,
// plus the sticky overrun flags and their clear strobe.
interface sample_rr_sched_if #(
    parameter int N = 4,
    parameter int W = 16
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [N*W-1:0] din_data;
    logic [N-1:0]   din_valid;
    logic [N-1:0]   din_ready;
    logic [W-1:0]   dout_data;
    logic [CW-1:0]  dout_ctrl;
    logic           dout_valid;
    logic           dout_ready;
    logic [N-1:0]   ovr;
    logic           ovr_clr;

    modport master (
        output din_data, din_valid, dout_ready, ovr_clr,
        input  din_ready, dout_data, dout_ctrl, dout_valid, ovr
    );

    modport slave (
        input  din_data, din_valid, dout_ready, ovr_clr,
        output din_ready, dout_data, dout_ctrl, dout_valid, ovr
    );
endinterface

// File: rtl/sample_rr_sched.sv
// Round-robin scheduler sharing one output between N latest-value channels;
// each grant is tagged with its channel index.
module sample_rr_sched #(
    parameter int           N          = 4,
    parameter int           W          = 16,
    parameter logic [W-1:0] INIT       = '0,
    parameter bit           INIT_VALID = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    sample_rr_sched_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0]   din_arr [N];
    logic [W-1:0]   reg_q   [N];
    logic [W-1:0]   reg_d   [N];
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   ovr_q, ovr_d;
    logic [CW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]   dout_data_q, dout_data_d;
    logic [CW-1:0]  dout_ctrl_q, dout_ctrl_d;
    logic           dout_valid_q, dout_valid_d;

    logic [N-1:0]   req;
    logic [N-1:0]   ovr_set;
    logic [2*N-1:0] dbl;
    logic [CW-1:0]  off;
    logic [CW:0]    sum;
    logic [CW-1:0]  win;
    logic           load;
    logic           grant;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign din_arr[g] = bus.din_data[g*W +: W];
    end

    // Rotate requests so ptr sits at bit 0, pick the lowest, rotate back.
    always_comb begin
        req = pend_q | bus.din_valid;
        dbl = {req, req} >> ptr_q;
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (dbl[i]) off = CW'(i);
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= (CW+1)'(N)) win = CW'(sum - (CW+1)'(N));
        else                   win = CW'(sum);
    end

    always_comb begin
        load  = !dout_valid_q || bus.dout_ready;
        grant = load && (|req);

        reg_d        = reg_q;
        pend_d       = pend_q;
        ptr_d        = ptr_q;
        dout_data_d  = dout_data_q;
        dout_ctrl_d  = dout_ctrl_q;
        dout_valid_d = dout_valid_q;

        for (int i = 0; i < N; i++) begin
            ovr_set[i] = bus.din_valid[i] && pend_q[i] &&
                         !(grant && (win == CW'(i)));
            if (bus.din_valid[i]) begin
                reg_d[i]  = din_arr[i];
                pend_d[i] = 1'b1;
            end
        end

        if (grant) begin
            dout_data_d  = bus.din_valid[win] ? din_arr[win] : reg_q[win];
            dout_ctrl_d  = win;
            dout_valid_d = 1'b1;
            pend_d[win]  = 1'b0;
            ptr_d        = (win == CW'(N - 1)) ? '0 : win + CW'(1);
        end else if (load) begin
            dout_valid_d = 1'b0;
        end

        // A fresh overrun outranks the clear strobe.
        ovr_d = (bus.ovr_clr ? '0 : ovr_q) | ovr_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) reg_q[i] <= INIT;
            pend_q       <= {N{INIT_VALID}};
            ovr_q        <= '0;
            ptr_q        <= '0;
            dout_data_q  <= '0;
            dout_ctrl_q  <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            reg_q        <= reg_d;
            pend_q       <= pend_d;
            ovr_q        <= ovr_d;
            ptr_q        <= ptr_d;
            dout_data_q  <= dout_data_d;
            dout_ctrl_q  <= dout_ctrl_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bus.din_ready  = '1;
    assign bus.dout_data  = dout_data_q;
    assign bus.dout_ctrl  = dout_ctrl_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.ovr        = ovr_q;
endmodule

// File: tb/tb_sample_rr_sched.sv
// Bench for sample_rr_sched: directed scenarios plus randomized traffic
// against a behavioural model of the scheduling rules.
module tb_sample_rr_sched;
    localparam int N = 4;
    localparam int W = 16;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst1 = 1'b1;

    int checks   = 0;
    int failures = 0;

    sample_rr_sched_if #(.N(N), .W(W)) b  ();
    sample_rr_sched_if #(.N(N), .W(W)) b1 ();

    sample_rr_sched #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    sample_rr_sched #(
        .N(N), .W(W), .INIT(16'h5A5A), .INIT_VALID(1'b1)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    always #5 clk = ~clk;

    // Model state: latest value and pending flag per channel, rotation pointer
    logic [W-1:0] mreg [N];
    bit           mpend [N];
    int           mptr;
    logic [N-1:0] movr;
    logic         ev;
    logic [W-1:0] ed;
    logic [1:0]   ec;

    task automatic model_step();
        int  w;
        bit  ld;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mreg[i]  = '0;
                mpend[i] = 1'b0;
            end
            mptr = 0; movr = '0; ev = 1'b0; ed = '0; ec = '0;
            return;
        end
        ld = !ev || b.dout_ready;
        w  = -1;
        if (ld) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (w < 0 && (mpend[j] || b.din_valid[j])) w = j;
            end
        end
        if (b.ovr_clr) movr = '0;
        for (int i = 0; i < N; i++)
            if (b.din_valid[i] && mpend[i] && i != w) movr[i] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (b.din_valid[i]) begin
                mreg[i]  = b.din_data[i*W +: W];
                mpend[i] = 1'b1;
            end
        end
        if (w >= 0) begin
            ed       = mreg[w];
            ec       = 2'(w);
            ev       = 1'b1;
            mpend[w] = 1'b0;
            mptr     = (w + 1) % N;
        end else if (ld) begin
            ev = 1'b0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b.din_valid = '0;
        b.ovr_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b.din_valid  = '1;
        b.din_data   = {$urandom, $urandom};
        b.dout_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({b.dout_valid, b.dout_ctrl, b.dout_data} !== 19'h0) begin
            failures++;
            $display("FAIL reset_out got v=%0b c=%0d d=%h want 0/0/0",
                     b.dout_valid, b.dout_ctrl, b.dout_data);
        end
        checks++;
        if (b.ovr !== 4'b0000 || b.din_ready !== 4'b1111) begin
            failures++;
            $display("FAIL reset_flags got ovr=%b rdy=%b want 0000/1111",
                     b.ovr, b.din_ready);
        end
        rst = 1'b0;
        b.din_valid = '0;
        tick();
        checks++;
        if (b.dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop got v=%0b want 0", b.dout_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        b.dout_ready = 1'b1;
        b.din_valid  = 4'b0100;
        b.din_data   = {16'h0, 16'h00AA, 16'h0, 16'h0};
        tick();
        b.din_valid = '0;
        checks++;
        if ({b.dout_valid, b.dout_ctrl, b.dout_data} !== {1'b1, 2'd2, 16'h00AA}) begin
            failures++;
            $display("FAIL single_grant got v=%0b c=%0d d=%h want 1/2/00aa",
                     b.dout_valid, b.dout_ctrl, b.dout_data);
        end
        tick();
        checks++;
        if (b.dout_valid !== 1'b0 || b.ovr !== 4'b0000) begin
            failures++;
            $display("FAIL single_idle got v=%0b ovr=%b want 0/0000",
                     b.dout_valid, b.ovr);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        b.dout_ready = 1'b1;
        b.din_valid  = 4'b1111;
        b.din_data   = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (b.dout_valid !== 1'b1 || b.dout_ctrl !== 2'(k % 4) ||
                b.dout_data !== 16'(16'h10 + k % 4)) begin
                failures++;
                $display("FAIL rotation[%0d] got v=%0b c=%0d d=%h want 1/%0d/%h",
                         k, b.dout_valid, b.dout_ctrl, b.dout_data,
                         k % 4, 16'h10 + k % 4);
            end
            if (k == 1) begin
                checks++;
                if (b.ovr !== 4'b1100) begin
                    failures++;
                    $display("FAIL rotation_ovr got %b want 1100", b.ovr);
                end
            end
        end
        checks++;
        if (b.ovr !== movr) begin
            failures++;
            $display("FAIL rotation_ovr_end got %b want %b", b.ovr, movr);
        end
        b.din_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        b.dout_ready = 1'b0;
        b.din_valid  = 4'b0010;
        b.din_data   = {16'h0, 16'h0, 16'h0001, 16'h0};
        tick();
        for (int c = 0; c < 5; c++) begin
            b.din_valid = (c < 2) ? 4'b0010 : 4'b0000;
            b.din_data  = {16'h0, 16'h0, 16'(c + 2), 16'h0};
            tick();
            checks++;
            if ({b.dout_valid, b.dout_ctrl, b.dout_data} !== {1'b1, 2'd1, 16'h0001}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%0b c=%0d d=%h want 1/1/0001",
                         c, b.dout_valid, b.dout_ctrl, b.dout_data);
            end
        end
        b.din_valid  = '0;
        b.dout_ready = 1'b1;
        tick();
        checks++;
        if ({b.dout_valid, b.dout_ctrl, b.dout_data} !== {1'b1, 2'd1, 16'h0003}) begin
            failures++;
            $display("FAIL bp_release got v=%0b c=%0d d=%h want 1/1/0003",
                     b.dout_valid, b.dout_ctrl, b.dout_data);
        end
        checks++;
        if (b.ovr !== 4'b0010) begin
            failures++;
            $display("FAIL bp_ovr got %b want 0010", b.ovr);
        end
        tick();
        b.ovr_clr = 1'b1;
        tick();
        b.ovr_clr = 1'b0;
        checks++;
        if (b.dout_valid !== 1'b0 || b.ovr !== 4'b0000) begin
            failures++;
            $display("FAIL bp_clear got v=%0b ovr=%b want 0/0000",
                     b.dout_valid, b.ovr);
        end
    endtask

    task automatic test_wrap_clear();
        do_reset();
        b.dout_ready = 1'b1;
        b.din_valid  = 4'b0100;
        b.din_data   = {16'h0333, 16'h0222, 16'h0111, 16'h0AAA};
        tick();
        b.dout_ready = 1'b0;
        b.din_valid  = 4'b1001;
        tick();
        b.dout_ready = 1'b1;
        b.din_valid  = '0;
        tick();
        checks++;
        if ({b.dout_valid, b.dout_ctrl, b.dout_data} !== {1'b1, 2'd3, 16'h0333}) begin
            failures++;
            $display("FAIL wrap_ch3 got v=%0b c=%0d d=%h want 1/3/0333",
                     b.dout_valid, b.dout_ctrl, b.dout_data);
        end
        tick();
        checks++;
        if ({b.dout_valid, b.dout_ctrl, b.dout_data} !== {1'b1, 2'd0, 16'h0AAA}) begin
            failures++;
            $display("FAIL wrap_ch0 got v=%0b c=%0d d=%h want 1/0/0aaa",
                     b.dout_valid, b.dout_ctrl, b.dout_data);
        end
        b.din_valid = 4'b0011;
        tick();
        checks++;
        if (b.dout_ctrl !== 2'd1 || b.dout_data !== 16'h0111) begin
            failures++;
            $display("FAIL wrap_ptr got c=%0d d=%h want 1/0111",
                     b.dout_ctrl, b.dout_data);
        end
        b.dout_ready = 1'b0;
        b.din_valid  = 4'b0001;
        b.ovr_clr    = 1'b1;
        tick();
        b.ovr_clr   = 1'b0;
        b.din_valid = '0;
        checks++;
        if (b.ovr !== 4'b0001) begin
            failures++;
            $display("FAIL set_beats_clr got %b want 0001", b.ovr);
        end
    endtask

    task automatic test_init_valid();
        b1.din_valid  = '0;
        b1.din_data   = '0;
        b1.ovr_clr    = 1'b0;
        b1.dout_ready = 1'b1;
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        for (int k = 0; k < N; k++) begin
            tick();
            checks++;
            if ({b1.dout_valid, b1.dout_ctrl, b1.dout_data} !== {1'b1, 2'(k), 16'h5A5A}) begin
                failures++;
                $display("FAIL init_valid[%0d] got v=%0b c=%0d d=%h want 1/%0d/5a5a",
                         k, b1.dout_valid, b1.dout_ctrl, b1.dout_data, k);
            end
        end
        tick();
        checks++;
        if (b1.dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL init_valid_end got v=%0b want 0", b1.dout_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        b.dout_ready = 1'b0;
        b.din_valid  = 4'b1111;
        b.din_data   = {$urandom, $urandom};
        tick();
        b.din_data   = {$urandom, $urandom};
        tick();
        checks++;
        if (b.dout_valid !== 1'b1 || b.ovr !== movr) begin
            failures++;
            $display("FAIL midrst_pre got v=%0b ovr=%b want 1/%b",
                     b.dout_valid, b.ovr, movr);
        end
        rst = 1'b1;
        b.din_valid = '0;
        tick();
        rst = 1'b0;
        checks++;
        if (b.dout_valid !== 1'b0 || b.ovr !== 4'b0000) begin
            failures++;
            $display("FAIL midrst got v=%0b ovr=%b want 0/0000",
                     b.dout_valid, b.ovr);
        end
        b.dout_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (b.dout_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_quiet[%0d] got v=%0b want 0",
                         k, b.dout_valid);
            end
        end
        b.din_valid = 4'b0100;
        b.din_data  = {16'h0, 16'hBEEF, 16'h0, 16'h0};
        tick();
        b.din_valid = '0;
        checks++;
        if ({b.dout_valid, b.dout_ctrl, b.dout_data} !== {1'b1, 2'd2, 16'hBEEF}) begin
            failures++;
            $display("FAIL midrst_resume got v=%0b c=%0d d=%h want 1/2/beef",
                     b.dout_valid, b.dout_ctrl, b.dout_data);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            b.din_valid  = 4'($urandom);
            b.din_data   = {$urandom, $urandom};
            b.dout_ready = ($urandom_range(0, 3) != 0);
            b.ovr_clr    = ($urandom_range(0, 15) == 0);
            rst          = ($urandom_range(0, 63) == 0);
            tick();
            checks++;
            if ({b.dout_valid, b.dout_ctrl, b.dout_data, b.ovr} !==
                {ev, ec, ed, movr}) begin
                failures++;
                $display("FAIL random[%0d] got v=%0b c=%0d d=%h ovr=%b want %0b/%0d/%h/%b",
                         k, b.dout_valid, b.dout_ctrl, b.dout_data, b.ovr,
                         ev, ec, ed, movr);
            end
        end
        rst = 1'b0;
        b.din_valid = '0;
        b.ovr_clr = 1'b0;
    endtask

    initial begin
        b.din_valid  = '0;
        b.din_data   = '0;
        b.dout_ready = 1'b1;
        b.ovr_clr    = 1'b0;
        b1.din_valid  = '0;
        b1.din_data   = '0;
        b1.dout_ready = 1'b1;
        b1.ovr_clr    = 1'b0;
        #2;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_wrap_clear();
        test_init_valid();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
